// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types for the configuration-chain bitstream loader.
// FSM state encoding used by the top-level sequencer.
package ccff_loader_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_FETCH = 3'd1;
  localparam logic [2:0] ENC_SHIFT = 3'd2;
  localparam logic [2:0] ENC_DRAIN = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ENC_IDLE,
    FETCH = ENC_FETCH,
    SHIFT = ENC_SHIFT,
    DRAIN = ENC_DRAIN,
    DONE  = ENC_DONE
  } state_e;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream-in and readback-out valid/ready streams.
// slave is the loader's view, master the producer/consumer view.
interface ccff_bitstream_loader_if #(
  parameter int DATA_W = 8
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/ccff_bitstream_loader_rb_packer.sv
// Serial-to-word packer for chain readback: accumulator plus
// one output holding register, with lookahead stall and flush.
module ccff_rb_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic              bit_i,
  input  logic              flush_i,
  input  logic              m_ready_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              stall_o,
  output logic              empty_o
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] acc_sh;
  logic              accept;

  assign accept = vld_q & m_ready_i;
  assign acc_sh = {acc_q[DATA_W-2:0], bit_i};

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (accept) vld_d = 1'b0;
    if (cap_i) begin
      if (cnt_q == CW'(DATA_W - 1)) begin
        out_d = acc_sh;
        vld_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sh;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (flush_i && cnt_q != '0 &&
                 (!vld_q || accept)) begin
      // left-justify the partial word, zero padded
      out_d = acc_q << (CW'(DATA_W) - cnt_q);
      vld_d = 1'b1;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // next capture would complete a word while output still held
  assign stall_o   = vld_d && (cnt_d == CW'(DATA_W - 1));
  assign empty_o   = !vld_q && (cnt_q == '0);
  assign m_valid_o = vld_q;
  assign m_data_o  = out_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto ccff_head, gates the chain clock
// and packs ccff_tail bits into readback words.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 20
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] chain_len,
  output logic             ccff_head,
  input  logic             ccff_tail,
  output logic             chain_clk_en,
  ccff_bitstream_loader_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             err_len0
);

  localparam int BW = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  rem_q;
  logic [BW-1:0]     biw_q;
  logic              en_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              stall;
  logic              rb_empty;

  ccff_rb_packer #(.DATA_W(DATA_W)) u_rb (
    .clk       (prog_clk),
    .rst_n     (pReset_n),
    .cap_i     (en_q),
    .bit_i     (ccff_tail),
    .flush_i   (state_q == DRAIN),
    .m_ready_i (bus.m_ready),
    .m_valid_o (bus.m_valid),
    .m_data_o  (bus.m_data),
    .stall_o   (stall),
    .empty_o   (rb_empty)
  );

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      rem_q     <= '0;
      biw_q     <= '0;
      en_q      <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (chain_len == '0) begin
            err_q <= 1'b1;
          end else begin
            state_q   <= FETCH;
            busy_q    <= 1'b1;
            rem_q     <= chain_len;
            s_ready_q <= 1'b1;
          end
        end
        FETCH: if (bus.s_valid && s_ready_q) begin
          shift_q   <= bus.s_data;
          biw_q     <= BW'(DATA_W);
          s_ready_q <= 1'b0;
          en_q      <= !stall;
          state_q   <= SHIFT;
        end
        SHIFT: if (en_q) begin
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          rem_q   <= rem_q - CNT_W'(1);
          biw_q   <= biw_q - BW'(1);
          if (rem_q == CNT_W'(1)) begin
            en_q    <= 1'b0;
            state_q <= DRAIN;
          end else if (biw_q == BW'(1)) begin
            en_q      <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= FETCH;
          end else begin
            en_q <= !stall;
          end
        end else begin
          en_q <= !stall;
        end
        DRAIN: if (rb_empty) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ccff_head    = shift_q[DATA_W-1];
  assign chain_clk_en = en_q;
  assign bus.s_ready  = s_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_len0     = err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: gated-clock chain model,
// directed table plus randomized loads against a bit-queue model.
module tb_ccff_bitstream_loader;

  localparam int DW = 8;
  localparam int CW = 20;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] chain_len = '0;
  logic          ccff_head, ccff_tail, chain_clk_en;
  logic          busy, done, err_len0;

  ccff_bitstream_loader_if #(.DATA_W(DW)) bus ();

  ccff_bitstream_loader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .chain_len    (chain_len),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .chain_clk_en (chain_clk_en),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_len0     (err_len0)
  );

  always #5 prog_clk = ~prog_clk;

  logic [63:0] chain;
  logic        chain_clr = 1'b1;
  int          clen = 16;

  always @(posedge prog_clk)
    if (chain_clr) chain <= '0;
    else if (chain_clk_en) chain <= {chain[62:0], ccff_head};

  assign ccff_tail = chain[6'(clen - 1)];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] msk(int l);
    return (64'd1 << l) - 64'd1;
  endfunction

  logic [7:0]  wq[$];
  logic [7:0]  got[$];
  logic [7:0]  expq[$];
  logic [63:0] exp_chain;

  // chain ends up holding the first L stream bits; readback is the
  // prior contents, tail bit first, grouped and zero padded
  task automatic model(input int l, input logic [63:0] prior);
    bit bs[$];
    logic [7:0] v;
    bs = {};
    foreach (wq[i])
      for (int b = 7; b >= 0; b--) bs.push_back(wq[i][b]);
    exp_chain = '0;
    for (int i = 0; i < l; i++)
      exp_chain = (exp_chain << 1) | 64'(bs[i]);
    expq = {};
    for (int i = 0; i < l; i += DW) begin
      v = '0;
      for (int j = 0; j < DW; j++)
        v = {v[6:0], (i + j < l) ? prior[6'(l - 1 - i - j)] : 1'b0};
      expq.push_back(v);
    end
  endtask

  // mode 0: plain, 1: random handshakes, 2: backpressure, 3: gaps
  task automatic run_load(input int l, input int mode);
    logic [63:0] prior;
    int idx, gap, bpwin, bpviol, gapviol, edges, consumed, dones;
    logic hd, seen_mv;
    idx = 0; gap = 0; bpwin = 0; bpviol = 0; gapviol = 0;
    edges = 0; consumed = 0; dones = 0; hd = 1'b0; seen_mv = 1'b0;
    clen = l;
    prior = chain & msk(l);
    model(l, prior);
    got = {};
    @(negedge prog_clk);
    start = 1'b1;
    chain_len = CW'(l);
    @(negedge prog_clk);
    start = 1'b0;
    chk("busy_start", 64'(busy), 1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        dones = 1;
        chk("busy_at_done", 64'(busy), 0);
        break;
      end
      start = (mode == 3 && cyc == 2);
      chain_len = start ? CW'(5) : CW'(l);
      bus.s_valid = (gap == 0) &&
                    (mode != 1 || $urandom_range(0, 2) != 0);
      bus.s_data = (idx < wq.size()) ? wq[idx] : 8'h5A;
      if (mode == 2 && !seen_mv && bus.m_valid) begin
        seen_mv = 1'b1;
        bpwin = 20;
      end
      if (mode == 1) bus.m_ready = ($urandom_range(0, 1) == 1);
      else bus.m_ready = (bpwin == 0);
      if (bpwin > 0 && bpwin <= 10) begin
        if (chain_clk_en) bpviol++;
        if (bpwin == 10) hd = ccff_head;
        else if (ccff_head !== hd) bpviol++;
      end
      if (bpwin > 0) bpwin--;
      if (mode == 3 && gap > 0 && bus.s_ready && chain_clk_en)
        gapviol++;
      if (chain_clk_en) edges++;
      if (bus.s_valid && bus.s_ready) begin
        consumed++;
        idx++;
        if (mode == 3) gap = 5;
      end else if (gap > 0 && bus.s_ready) begin
        gap--;
      end
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      @(negedge prog_clk);
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    chk("done_seen", 64'(dones), 1);
    chk("edges", 64'(edges), 64'(l));
    chk("words_in", 64'(consumed), 64'((l + DW - 1) / DW));
    chk("chain", chain & msk(l), exp_chain);
    chk("rb_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk("rb_word", 64'(got[i]), 64'(expq[i]));
    if (mode == 2) begin
      chk("bp_entered", 64'(seen_mv), 1);
      chk("bp_stall", 64'(bpviol), 0);
    end
    if (mode == 3) chk("gap_en", 64'(gapviol), 0);
    @(negedge prog_clk);
    chk("done_pulse", 64'(done), 0);
    chk("busy_end", 64'(busy), 0);
  endtask

  typedef struct {
    int          len;
    logic [7:0]  w0, w1;
    int          mode;
    logic [63:0] xchain;
    logic [7:0]  rb0, rb1;
  } vec_t;

  vec_t tbl[5];
  int   rdone;
  int   nl;

  initial begin
    tbl[0] = '{16, 8'hA5, 8'h3C, 0, 64'hA53C, 8'h00, 8'h00};
    tbl[1] = '{12, 8'hDE, 8'hAD, 0, 64'hDEA,  8'h53, 8'hC0};
    tbl[2] = '{16, 8'hFF, 8'h00, 0, 64'hFF00, 8'hCD, 8'hEA};
    tbl[3] = '{16, 8'hA5, 8'h3C, 2, 64'hA53C, 8'hFF, 8'h00};
    tbl[4] = '{16, 8'h12, 8'h34, 3, 64'h1234, 8'hA5, 8'h3C};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    #1;
    chk("reset_outs", 64'({ccff_head, chain_clk_en, busy, done,
        err_len0, bus.s_ready, bus.m_valid, bus.m_data}), 0);
    repeat (2) @(negedge prog_clk);
    pReset_n  = 1'b1;
    chain_clr = 1'b0;

    for (int t = 0; t < 5; t++) begin
      wq = {tbl[t].w0, tbl[t].w1};
      run_load(tbl[t].len, tbl[t].mode);
      chk("tbl_chain", chain & msk(tbl[t].len), tbl[t].xchain);
      chk("tbl_rb0", 64'(got.size() > 0 ? got[0] : 8'h00),
          64'(tbl[t].rb0));
      chk("tbl_rb1", 64'(got.size() > 1 ? got[1] : 8'h00),
          64'(tbl[t].rb1));
    end

    @(negedge prog_clk);
    start = 1'b1;
    chain_len = '0;
    @(negedge prog_clk);
    start = 1'b0;
    chk("err_len0_hi", 64'(err_len0), 1);
    chk("err_busy", 64'(busy), 0);
    @(negedge prog_clk);
    chk("err_len0_lo", 64'(err_len0), 0);
    chk("err_idle_rdy", 64'(bus.s_ready), 0);

    clen = 16;
    start = 1'b1;
    chain_len = CW'(16);
    @(negedge prog_clk);
    start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'hC3;
    repeat (4) @(negedge prog_clk);
    bus.s_valid = 1'b0;
    chk("rst_pre_en", 64'({busy, chain_clk_en}), 64'b11);
    #2 pReset_n = 1'b0;
    #1;
    chk("rst_async", 64'({ccff_head, chain_clk_en, busy, done,
        err_len0, bus.s_ready, bus.m_valid, bus.m_data}), 0);
    rdone = 0;
    repeat (3) begin
      @(negedge prog_clk);
      if (done || busy) rdone++;
    end
    pReset_n = 1'b1;
    @(negedge prog_clk);
    if (done || busy) rdone++;
    chk("rst_no_done", 64'(rdone), 0);
    wq = {8'h96, 8'h69};
    run_load(16, 0);

    for (int r = 0; r < 15; r++) begin
      nl = $urandom_range(1, 40);
      wq = {};
      for (int k = 0; k < (nl + DW - 1) / DW; k++)
        wq.push_back(8'($urandom));
      run_load(nl, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
